// File: rtl/debounce_multi.sv
// rtl/debounce_multi.sv - multi-channel counter-qualified debouncer with rise/fall pulses
module debounce_multi #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 16,
  parameter int PRESCALE    = 1000,
  parameter int INIT_LEVEL  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CHANNELS-1:0]  din,
  input  logic [CNT_WIDTH-1:0] hold_cnt,
  output logic [CHANNELS-1:0]  dout,
  output logic [CHANNELS-1:0]  rise,
  output logic [CHANNELS-1:0]  fall,
  output logic                 changed
);
  localparam int                  PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]       PLAST    = PW'(PRESCALE - 1);
  localparam logic [CHANNELS-1:0] INIT_VEC = {CHANNELS{INIT_LEVEL != 0}};

  logic [CHANNELS-1:0]  sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0]  sync_d [SYNC_STAGES];
  logic [CNT_WIDTH-1:0] cnt_q  [CHANNELS];
  logic [CNT_WIDTH-1:0] cnt_d  [CHANNELS];
  logic [PW-1:0]        pcnt_q, pcnt_d;
  logic [CHANNELS-1:0]  dout_q, dout_d;
  logic [CHANNELS-1:0]  rise_q, rise_d;
  logic [CHANNELS-1:0]  fall_q, fall_d;
  logic                 changed_q, changed_d;
  logic [CHANNELS-1:0]  s;
  logic                 tick;
  logic [CNT_WIDTH-1:0] hold_last;

  always_comb begin
    sync_d[0] = din;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  assign s         = sync_q[SYNC_STAGES-1];
  assign tick      = (pcnt_q == PLAST);
  assign pcnt_d    = tick ? '0 : pcnt_q + 1'b1;
  // hold_cnt of 0 behaves as 1, so the last counter value before commit is 0
  assign hold_last = (hold_cnt == '0) ? '0 : hold_cnt - 1'b1;

  always_comb begin
    cnt_d  = cnt_q;
    dout_d = dout_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (s[i] == dout_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        // >= lets a lowered hold_cnt commit on the very next tick
        if (cnt_q[i] >= hold_last) begin
          cnt_d[i]  = '0;
          dout_d[i] = s[i];
          rise_d[i] = s[i];
          fall_d[i] = ~s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    changed_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= INIT_VEC;
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
      pcnt_q    <= '0;
      dout_q    <= INIT_VEC;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      pcnt_q    <= pcnt_d;
      dout_q    <= dout_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

  assign dout    = dout_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign changed = changed_q;
endmodule
